// File: rtl/wb_write_arbiter_if.sv
// Writeback arbiter bus bundle.
// Groups the two source push ports, the register-file write port and the
// pending-write tracking signals of wb_write_arbiter.
//   master : the side that produces results / claims / source lookups
//   slave  : the arbiter itself
interface wb_write_arbiter_if;
    logic        s0_valid;
    logic        s0_ready;
    logic [4:0]  s0_rd;
    logic [31:0] s0_data;
    logic        s1_valid;
    logic        s1_ready;
    logic [4:0]  s1_rd;
    logic [31:0] s1_data;
    logic        write_en;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic        mark_valid;
    logic [4:0]  mark_rd;
    logic [4:0]  rs1_in;
    logic [4:0]  rs2_in;
    logic        rs1_busy;
    logic        rs2_busy;

    modport master (
        output s0_valid, s0_rd, s0_data, input s0_ready,
        output s1_valid, s1_rd, s1_data, input s1_ready,
        input  write_en, rd, write_data,
        output mark_valid, mark_rd, rs1_in, rs2_in,
        input  rs1_busy, rs2_busy
    );

    modport slave (
        input  s0_valid, s0_rd, s0_data, output s0_ready,
        input  s1_valid, s1_rd, s1_data, output s1_ready,
        output write_en, rd, write_data,
        input  mark_valid, mark_rd, rs1_in, rs2_in,
        output rs1_busy, rs2_busy
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter
// Merges writeback results from two sources (src0 = ALU/CSR, src1 = load /
// accelerator return) onto the single register-file write port. Each source
// has its own DEPTH-entry FIFO; heads are arbitrated by fixed priority
// (PRIORITY_RR=0, src0 wins) or round-robin (PRIORITY_RR=1). The winning head
// is popped into a registered output, so write_en pulses one cycle per entry.
// Ports:
//   clk    core clock
//   rst_n  asynchronous active-low reset
//   bus    wb_write_arbiter_if.slave: s0/s1 push ports, write_en/rd/write_data,
//          mark_*/rs*_in/rs*_busy pending-write tracking
// Optional feature: define WB_SCOREBOARD_EN to build the 32-entry busy vector;
// otherwise rs1_busy/rs2_busy are tied to 0 and mark_* are ignored.
module wb_write_arbiter #(
    parameter int DEPTH       = 2,
    parameter bit PRIORITY_RR = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    wb_write_arbiter_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [36:0] entry_t;   // {rd, data}

    entry_t        mem_q [2][DEPTH];
    logic [AW-1:0] wr_ptr_q [2];
    logic [AW-1:0] wr_ptr_d [2];
    logic [AW-1:0] rd_ptr_q [2];
    logic [AW-1:0] rd_ptr_d [2];
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    entry_t        in_entry [2];
    entry_t        head [2];
    logic [1:0]    valid_in, ready, push, nonempty, gnt;
    logic          rr_q, rr_d;          // 1: src1 is preferred on a tie
    logic          we_q, we_d;
    logic [4:0]    rd_q, rd_d;
    logic [31:0]   data_q, data_d;
    entry_t        grant_entry;
    logic          any_gnt;

    always_comb begin
        valid_in    = {bus.s1_valid, bus.s0_valid};
        in_entry[0] = {bus.s0_rd, bus.s0_data};
        in_entry[1] = {bus.s1_rd, bus.s1_data};
        for (int i = 0; i < 2; i++) begin
            // Ready depends only on the registered count: a pop on the same
            // edge never lets a push into a full FIFO.
            ready[i]    = rst_n && (cnt_q[i] != CW'(DEPTH));
            push[i]     = valid_in[i] && ready[i];
            nonempty[i] = (cnt_q[i] != '0);
            head[i]     = mem_q[i][rd_ptr_q[i]];
        end
    end

    assign bus.s0_ready = ready[0];
    assign bus.s1_ready = ready[1];

    always_comb begin
        gnt  = nonempty;
        rr_d = rr_q;
        if (nonempty == 2'b11)
            gnt = (PRIORITY_RR && rr_q) ? 2'b10 : 2'b01;
        if (gnt[0])
            rr_d = 1'b1;
        else if (gnt[1])
            rr_d = 1'b0;
    end

    always_comb begin
        any_gnt     = |gnt;
        grant_entry = gnt[1] ? head[1] : head[0];
        // A granted head addressed to x0 is consumed without a write strobe.
        we_d   = any_gnt && (grant_entry[36:32] != 5'd0);
        rd_d   = any_gnt ? grant_entry[36:32] : rd_q;
        data_d = any_gnt ? grant_entry[31:0] : data_q;
        for (int i = 0; i < 2; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + AW'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + AW'(gnt[i]);
            cnt_d[i]    = cnt_q[i] + CW'(push[i]) - CW'(gnt[i]);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            if (push[i])
                mem_q[i][wr_ptr_q[i]] <= in_entry[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            rr_q   <= 1'b0;
            we_q   <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            rr_q   <= rr_d;
            we_q   <= we_d;
            rd_q   <= rd_d;
            data_q <= data_d;
        end
    end

    assign bus.write_en   = we_q;
    assign bus.rd         = rd_q;
    assign bus.write_data = data_q;

`ifdef WB_SCOREBOARD_EN
    logic [31:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (any_gnt)
            busy_d[grant_entry[36:32]] = 1'b0;
        // Applied after the clear so a new claim on the retiring register survives.
        if (bus.mark_valid)
            busy_d[bus.mark_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    assign bus.rs1_busy = busy_q[bus.rs1_in];
    assign bus.rs2_busy = busy_q[bus.rs2_in];
`else
    logic unused_sb;
    assign unused_sb    = ^{bus.mark_valid, bus.mark_rd, bus.rs1_in, bus.rs2_in};
    assign bus.rs1_busy = 1'b0;
    assign bus.rs2_busy = 1'b0;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // sel=0 routes source stimulus to dut_a (round-robin), sel=1 to dut_b (fixed priority)
    logic        sel;
    logic        s0_valid, s1_valid;
    logic [4:0]  s0_rd, s1_rd;
    logic [31:0] s0_data, s1_data;
    logic        mark_valid;
    logic [4:0]  mark_rd, rs1_in, rs2_in;

    wb_write_arbiter_if ifa ();
    wb_write_arbiter_if ifb ();

    assign ifa.s0_valid = s0_valid & ~sel;
    assign ifa.s1_valid = s1_valid & ~sel;
    assign ifb.s0_valid = s0_valid & sel;
    assign ifb.s1_valid = s1_valid & sel;
    assign ifa.s0_rd = s0_rd;     assign ifb.s0_rd = s0_rd;
    assign ifa.s0_data = s0_data; assign ifb.s0_data = s0_data;
    assign ifa.s1_rd = s1_rd;     assign ifb.s1_rd = s1_rd;
    assign ifa.s1_data = s1_data; assign ifb.s1_data = s1_data;
    assign ifa.mark_valid = mark_valid; assign ifb.mark_valid = mark_valid;
    assign ifa.mark_rd = mark_rd; assign ifb.mark_rd = mark_rd;
    assign ifa.rs1_in = rs1_in;   assign ifb.rs1_in = rs1_in;
    assign ifa.rs2_in = rs2_in;   assign ifb.rs2_in = rs2_in;

    wire rdy0 = sel ? ifb.s0_ready : ifa.s0_ready;
    wire rdy1 = sel ? ifb.s1_ready : ifa.s1_ready;

    wb_write_arbiter #(.DEPTH(2), .PRIORITY_RR(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    wb_write_arbiter #(.DEPTH(2), .PRIORITY_RR(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    int checks = 0;
    int errors = 0;

    logic [36:0] qa [$];       // expected writes of dut_a, in order
    logic [36:0] qb [$];       // expected writes of dut_b, in order
    logic [36:0] s0_list [$];  // entries still to be pushed on src0
    logic [36:0] s1_list [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ifa.write_en === 1'b1) begin
            chk("a_write_expected", 64'(qa.size() != 0), 64'd1);
            if (qa.size() != 0) chk("a_write_value", 64'({ifa.rd, ifa.write_data}), 64'(qa.pop_front()));
        end
        if (ifb.write_en === 1'b1) begin
            chk("b_write_expected", 64'(qb.size() != 0), 64'd1);
            if (qb.size() != 0) chk("b_write_value", 64'({ifb.rd, ifb.write_data}), 64'(qb.pop_front()));
        end
    end

    // Called just after a posedge; returns just after the edge of the last push.
    task automatic drive0();
        int  guard = 0;
        logic acc;
        while (s0_list.size() != 0 && guard < 200) begin
            s0_valid = 1'b1; s0_rd = s0_list[0][36:32]; s0_data = s0_list[0][31:0];
            @(negedge clk); acc = rdy0;
            @(posedge clk); #1;
            if (acc) void'(s0_list.pop_front());
            guard++;
        end
        s0_valid = 1'b0;
        chk("src0_push_timeout", 64'(s0_list.size()), 64'd0);
    endtask

    task automatic drive1();
        int  guard = 0;
        logic acc;
        while (s1_list.size() != 0 && guard < 200) begin
            s1_valid = 1'b1; s1_rd = s1_list[0][36:32]; s1_data = s1_list[0][31:0];
            @(negedge clk); acc = rdy1;
            @(posedge clk); #1;
            if (acc) void'(s1_list.pop_front());
            guard++;
        end
        s1_valid = 1'b0;
        chk("src1_push_timeout", 64'(s1_list.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; sel = 1'b0;
        s0_valid = 1'b0; s0_rd = '0; s0_data = '0;
        s1_valid = 1'b0; s1_rd = '0; s1_data = '0;
        mark_valid = 1'b0; mark_rd = '0; rs1_in = '0; rs2_in = '0;

        // reset state
        #2;
        chk("rst_we", 64'(ifa.write_en), 64'd0);
        chk("rst_rd", 64'(ifa.rd), 64'd0);
        chk("rst_data", 64'(ifa.write_data), 64'd0);
        chk("rst_s0_ready", 64'(ifa.s0_ready), 64'd0);
        chk("rst_s1_ready", 64'(ifa.s1_ready), 64'd0);
        chk("rst_b_s0_ready", 64'(ifb.s0_ready), 64'd0);
        chk("rst_busy", 64'({ifa.rs1_busy, ifa.rs2_busy}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rel_s0_ready", 64'(ifa.s0_ready), 64'd1);
        chk("rel_s1_ready", 64'(ifa.s1_ready), 64'd1);

        // single push: write_en exactly one cycle, two edges after the push
        s0_list.push_back({5'd5, 32'hDEADBEEF});
        qa.push_back({5'd5, 32'hDEADBEEF});
        drive0();
        @(negedge clk); chk("lat_not_yet", 64'(ifa.write_en), 64'd0);
        @(negedge clk); chk("lat_hit", 64'(ifa.write_en), 64'd1);
        @(negedge clk); chk("one_cycle_wide", 64'(ifa.write_en), 64'd0);
        repeat (2) @(posedge clk); #1;

        // round-robin: both sources busy, outputs alternate s0,s1,...
        do_reset();
        for (int i = 0; i < 4; i++) begin
            s0_list.push_back({5'(i + 1), 32'hA000_0000 + 32'(i)});
            s1_list.push_back({5'(i + 17), 32'hB000_0000 + 32'(i)});
            qa.push_back({5'(i + 1), 32'hA000_0000 + 32'(i)});
            qa.push_back({5'(i + 17), 32'hB000_0000 + 32'(i)});
        end
        fork
            drive0();
            drive1();
        join
        repeat (10) @(posedge clk); #1;
        chk("rr_drained", 64'(qa.size()), 64'd0);

        // fixed priority: s1 starved while s0 streams, s1 FIFO fills
        sel = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s0_list.push_back({5'(i + 10), 32'hC000_0000 + 32'(i)});
            qb.push_back({5'(i + 10), 32'hC000_0000 + 32'(i)});
        end
        for (int i = 0; i < 2; i++) begin
            s1_list.push_back({5'(i + 20), 32'hD000_0000 + 32'(i)});
            qb.push_back({5'(i + 20), 32'hD000_0000 + 32'(i)});
        end
        fork
            drive0();
            drive1();
        join
        @(negedge clk); chk("b_s1_full_ready", 64'(ifb.s1_ready), 64'd0);
        repeat (10) @(posedge clk); #1;
        chk("prio_drained", 64'(qb.size()), 64'd0);
        sel = 1'b0;

        // rd=0 entry is consumed silently, the next one is written
        s0_list.push_back({5'd0, 32'h0000_1234});
        s0_list.push_back({5'd9, 32'hCAFE_F00D});
        qa.push_back({5'd9, 32'hCAFE_F00D});
        drive0();
        @(negedge clk); chk("x0_no_strobe", 64'(ifa.write_en), 64'd0);
        repeat (6) @(posedge clk); #1;
        chk("x0_drained", 64'(qa.size()), 64'd0);

        // reset while a write is in flight and another entry is buffered
        s0_list.push_back({5'd3, 32'h1111_1111});
        s1_list.push_back({5'd4, 32'h2222_2222});
        fork
            drive0();
            drive1();
        join
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_we", 64'(ifa.write_en), 64'd0);
        chk("midrst_ready", 64'(ifa.s1_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("midrst_rel_ready", 64'({ifa.s0_ready, ifa.s1_ready}), 64'd3);
        chk("midrst_rd", 64'({ifa.rd, ifa.write_data}), 64'd0);
        repeat (8) @(posedge clk); #1;

`ifdef WB_SCOREBOARD_EN
        rs1_in = 5'd7; rs2_in = 5'd3;
        mark_valid = 1'b1; mark_rd = 5'd7;
        @(posedge clk); #1 mark_valid = 1'b0;
        @(negedge clk);
        chk("sb_rs1_busy", 64'(ifa.rs1_busy), 64'd1);
        chk("sb_rs2_idle", 64'(ifa.rs2_busy), 64'd0);
        rs2_in = 5'd7; #1;
        chk("sb_rs2_busy", 64'(ifa.rs2_busy), 64'd1);
        @(posedge clk); #1;
        s0_list.push_back({5'd7, 32'h0000_0077});
        qa.push_back({5'd7, 32'h0000_0077});
        drive0();
        @(negedge clk); chk("sb_still_busy", 64'(ifa.rs1_busy), 64'd1);
        @(negedge clk);
        chk("sb_clear_we", 64'(ifa.write_en), 64'd1);
        chk("sb_cleared", 64'(ifa.rs1_busy), 64'd0);
        @(posedge clk); #1;
        mark_valid = 1'b1; mark_rd = 5'd7;
        @(posedge clk); #1 mark_valid = 1'b0;
        s0_list.push_back({5'd7, 32'h0000_0078});
        qa.push_back({5'd7, 32'h0000_0078});
        drive0();
        mark_valid = 1'b1; mark_rd = 5'd7;
        @(posedge clk); #1 mark_valid = 1'b0;
        @(negedge clk);
        chk("sb_setwins_we", 64'(ifa.write_en), 64'd1);
        chk("sb_set_wins", 64'(ifa.rs1_busy), 64'd1);
        repeat (3) @(posedge clk); #1;
        chk("sb_set_held", 64'(ifa.rs1_busy), 64'd1);
        mark_valid = 1'b1; mark_rd = 5'd0; rs1_in = 5'd0;
        @(posedge clk); #1 mark_valid = 1'b0;
        chk("sb_x0_never_busy", 64'(ifa.rs1_busy), 64'd0);
`else
        mark_valid = 1'b1; mark_rd = 5'd7; rs1_in = 5'd7; rs2_in = 5'd7;
        @(posedge clk); #1 mark_valid = 1'b0;
        @(negedge clk);
        chk("nosb_rs1", 64'(ifa.rs1_busy), 64'd0);
        chk("nosb_rs2", 64'(ifa.rs2_busy), 64'd0);
`endif

        repeat (4) @(posedge clk); #1;
        chk("final_qa_empty", 64'(qa.size()), 64'd0);
        chk("final_qb_empty", 64'(qb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
